// File: rtl/minterm_scan_pkg.sv
// Shared types and constants for the minterm scanner: FSM state encoding,
// vector/counter widths and the final index of a scan.
package minterm_scan_pkg;

    localparam int VEC_W = 5;
    localparam int CNT_W = 6;
    localparam logic [VEC_W-1:0] LAST_IDX = 5'd31;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SCAN = 2'b01,
        HOLD = 2'b10,
        DONE = 2'b11
    } state_e;

    function automatic logic is_last(input logic [VEC_W-1:0] idx);
        return (idx == LAST_IDX);
    endfunction

endpackage

// File: rtl/minterm_scan_func_eval.sv
// Purely combinational evaluation of f(v) = (v4 | v3) & v2 & (~v1 | v0)
// for one 5-bit input vector.
module func_eval
    import minterm_scan_pkg::*;
(
    input  logic [VEC_W-1:0] v,
    output logic             f
);

    assign f = (v[4] | v[3]) & v[2] & (~v[1] | v[0]);

endmodule

// File: rtl/minterm_scan.sv
// minterm_scan: walks idx 0..31 and hands out every input vector whose
// function value equals the latched target. Match counter: MINTERM_SCAN_COUNT_EN.
module minterm_scan
    import minterm_scan_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             target,
    input  logic             ready,
    output logic             busy,
    output logic             valid,
    output logic [VEC_W-1:0] vec,
    output logic             done,
    output logic [CNT_W-1:0] match_cnt
);

    state_e           state_r;
    state_e           state_s;
    logic [VEC_W-1:0] idx_r;
    logic [VEC_W-1:0] idx_s;
    logic [VEC_W-1:0] vec_r;
    logic [VEC_W-1:0] vec_s;
    logic             target_r;
    logic             target_s;
    logic             valid_r;
    logic             valid_s;
    logic             busy_r;
    logic             done_r;
    logic             f_s;
    logic             hit_s;

    func_eval u_func_eval (
        .v (idx_r),
        .f (f_s)
    );

    assign hit_s = (f_s == target_r);

    // Next-state and next-datapath logic for the scan FSM
    always_comb begin
        state_s  = state_r;
        idx_s    = idx_r;
        vec_s    = vec_r;
        target_s = target_r;
        valid_s  = valid_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    target_s = target;
                    idx_s    = {VEC_W{1'b0}};
                    state_s  = SCAN;
                end else begin
                    state_s  = IDLE;
                end
            end
            SCAN: begin
                if (hit_s) begin
                    vec_s   = idx_r;
                    valid_s = 1'b1;
                    state_s = HOLD;
                end else if (is_last(idx_r)) begin
                    state_s = DONE;
                end else begin
                    idx_s   = idx_r + 5'd1;
                    state_s = SCAN;
                end
            end
            HOLD: begin
                if (ready) begin
                    valid_s = 1'b0;
                    // idx 31 is evaluated once; leaving HOLD there ends the scan
                    if (is_last(idx_r)) begin
                        state_s = DONE;
                    end else begin
                        idx_s   = idx_r + 5'd1;
                        state_s = SCAN;
                    end
                end else begin
                    state_s = HOLD;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                valid_s = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // State and registered outputs; busy/done are decoded from the next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            idx_r    <= {VEC_W{1'b0}};
            vec_r    <= {VEC_W{1'b0}};
            target_r <= 1'b0;
            valid_r  <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            idx_r    <= idx_s;
            vec_r    <= vec_s;
            target_r <= target_s;
            valid_r  <= valid_s;
            busy_r   <= (state_s != IDLE);
            done_r   <= (state_s == DONE);
        end
    end

`ifdef MINTERM_SCAN_COUNT_EN
    logic [CNT_W-1:0] cnt_r;
    logic             cnt_clr_s;
    logic             cnt_inc_s;

    assign cnt_clr_s = (state_r == IDLE) && start;
    assign cnt_inc_s = (state_r == HOLD) && ready;

    // Match counter: cleared by an accepted start, bumped on each consumer accept
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_clr_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_inc_s) begin
            cnt_r <= cnt_r + 6'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign match_cnt = cnt_r;
`else
    assign match_cnt = {CNT_W{1'b0}};
`endif

    assign busy  = busy_r;
    assign valid = valid_r;
    assign vec   = vec_r;
    assign done  = done_r;

endmodule

// File: tb/tb_minterm_scan.sv
// Self-checking bench for minterm_scan: table-driven scans, hand-written
// backpressure/reset sequences and randomized scans against a reference model.
module tb_minterm_scan;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       target;
    logic       ready;
    logic       busy;
    logic       valid;
    logic [4:0] vec;
    logic       done;
    logic [5:0] match_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [4:0] got_q[$];
    int lat;
    int n_done;
    int hold_bad;
    int scan_cycles;

    typedef struct {
        logic tgt;
        int   pct;
        bit   poke;
        int   exp_n;
        int   exp_first;
        int   exp_last;
    } scan_rec_t;

    always #5 clk = ~clk;

    minterm_scan dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .target    (target),
        .ready     (ready),
        .busy      (busy),
        .valid     (valid),
        .vec       (vec),
        .done      (done),
        .match_cnt (match_cnt)
    );

    // f from its truth-table description: needs bit2, one of bit4/bit3, and bit1:0 != 2'b10
    function automatic int f_ref(input int i);
        int hi;
        int mid;
        int lo;
        hi  = (((i >> 3) & 3) != 0) ? 1 : 0;
        mid = (i >> 2) & 1;
        lo  = ((i & 3) == 2) ? 0 : 1;
        return hi & mid & lo;
    endfunction

    function automatic int exp_cnt(input int n);
`ifdef MINTERM_SCAN_COUNT_EN
        return n;
`else
        return n - n;
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full scan; records accepted vectors, first-valid latency, done pulses, hold stability
    task automatic run_scan(input logic tgt, input int pct, input bit poke);
        int         c;
        bit         prev_hold;
        logic [4:0] prev_vec;
        got_q.delete();
        lat       = -1;
        n_done    = 0;
        hold_bad  = 0;
        prev_hold = 1'b0;
        prev_vec  = 5'd0;
        target    = tgt;
        start     = 1'b1;
        tick();
        start  = 1'b0;
        target = ~tgt;
        c = 0;
        while (c < 300) begin
            if (valid === 1'b1 && lat < 0) lat = c;
            if (prev_hold && (valid !== 1'b1 || vec !== prev_vec)) hold_bad++;
            check("match_cnt tracks accepts", int'(match_cnt), exp_cnt(got_q.size()));
            if (done === 1'b1) n_done++;
            if (n_done > 0 && done !== 1'b1) break;
            ready = (int'($urandom_range(99)) < pct);
            if (valid === 1'b1 && ready) got_q.push_back(vec);
            prev_hold = (valid === 1'b1) && !ready;
            prev_vec  = vec;
            start     = poke && (c == 4);
            tick();
            c++;
        end
        start       = 1'b0;
        ready       = 1'b0;
        scan_cycles = c;
        check("scan ends within cycle bound", int'(c < 300), 1);
    endtask

    task automatic scan_and_check(input string tag, input logic tgt, input int pct, input bit poke);
        int ref_q[$];
        for (int i = 0; i < 32; i++) begin
            if (f_ref(i) == int'(tgt)) ref_q.push_back(i);
        end
        run_scan(tgt, pct, poke);
        check({tag, " match count"}, got_q.size(), ref_q.size());
        for (int k = 0; k < ref_q.size() && k < got_q.size(); k++) begin
            check({tag, " vec"}, int'(got_q[k]), ref_q[k]);
        end
        check({tag, " first-valid latency"}, lat, (ref_q.size() > 0) ? ref_q[0] + 1 : -1);
        check({tag, " done pulses"}, n_done, 1);
        check({tag, " hold stability"}, hold_bad, 0);
        check({tag, " busy after done"}, int'(busy), 0);
        check({tag, " match_cnt at end"}, int'(match_cnt), exp_cnt(ref_q.size()));
    endtask

    initial begin
        scan_rec_t tbl[3];
        int        c;
        int        n_acc;
        int        last_cnt;

        tbl[0] = '{tgt: 1'b1, pct: 100, poke: 1'b0, exp_n: 9,  exp_first: 12, exp_last: 31};
        tbl[1] = '{tgt: 1'b0, pct: 100, poke: 1'b0, exp_n: 23, exp_first: 0,  exp_last: 30};
        tbl[2] = '{tgt: 1'b1, pct: 100, poke: 1'b1, exp_n: 9,  exp_first: 12, exp_last: 31};

        rst_n  = 1'b0;
        start  = 1'b0;
        target = 1'b0;
        ready  = 1'b0;
        repeat (3) tick();
        check("reset busy", int'(busy), 0);
        check("reset valid", int'(valid), 0);
        check("reset vec", int'(vec), 0);
        check("reset done", int'(done), 0);
        check("reset match_cnt", int'(match_cnt), 0);
        rst_n = 1'b1;

        for (int t = 0; t < 3; t++) begin
            scan_and_check($sformatf("table[%0d]", t), tbl[t].tgt, tbl[t].pct, tbl[t].poke);
            check("table total", got_q.size(), tbl[t].exp_n);
            check("table first vec", (got_q.size() > 0) ? int'(got_q[0]) : -1, tbl[t].exp_first);
            check("table last vec", (got_q.size() > 0) ? int'(got_q[got_q.size() - 1]) : -1,
                  tbl[t].exp_last);
            last_cnt = int'(match_cnt);
            repeat (3) tick();
            check("match_cnt holds in idle", int'(match_cnt), last_cnt);
        end

        // Backpressure: ready low for 5 cycles at the first valid
        target = 1'b1;
        start  = 1'b1;
        ready  = 1'b0;
        tick();
        start = 1'b0;
        c = 0;
        while (valid !== 1'b1 && c < 50) begin
            tick();
            c++;
        end
        check("stall first-valid latency", c, 13);
        for (int k = 0; k < 5; k++) begin
            check("stall vec", int'(vec), 12);
            check("stall valid", int'(valid), 1);
            tick();
        end
        ready = 1'b1;
        check("stall vec before accept", int'(vec), 12);
        tick();
        check("valid drops after accept", int'(valid), 0);
        c = 0;
        while (valid !== 1'b1 && c < 50) begin
            tick();
            c++;
        end
        check("vec after release", int'(vec), 13);
        c = 0;
        while (busy === 1'b1 && c < 100) begin
            tick();
            c++;
        end
        check("stall scan match_cnt", int'(match_cnt), exp_cnt(9));
        ready = 1'b0;
        tick();

        // Reset while in HOLD holding vec 20
        target = 1'b1;
        start  = 1'b1;
        ready  = 1'b1;
        tick();
        start = 1'b0;
        c     = 0;
        n_acc = 0;
        while (!(valid === 1'b1 && vec === 5'd20) && c < 100) begin
            if (valid === 1'b1) n_acc++;
            tick();
            c++;
        end
        ready = 1'b0;
        check("reached vec 20", int'(vec), 20);
        tick();
        check("holding vec 20", int'(valid), 1);
        check("match_cnt before reset", int'(match_cnt), exp_cnt(n_acc));
        rst_n = 1'b0;
        tick();
        check("hold-reset busy", int'(busy), 0);
        check("hold-reset valid", int'(valid), 0);
        check("hold-reset vec", int'(vec), 0);
        check("hold-reset done", int'(done), 0);
        check("hold-reset match_cnt", int'(match_cnt), 0);
        rst_n = 1'b1;
        scan_and_check("rescan after reset", 1'b1, 100, 1'b0);

        for (int r = 0; r < 6; r++) begin
            scan_and_check($sformatf("random[%0d]", r), 1'($urandom_range(1, 0)),
                           int'($urandom_range(100, 20)), 1'($urandom_range(1, 0)));
            repeat (int'($urandom_range(3, 0))) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/minterm_scan.md
MINTERM_SCAN -- requirements
Module: minterm_scan

Interface
- REQ-001 SHALL have no parameters; vector width is fixed at 5 bits.
- REQ-002 Ports SHALL be:
  - clk  input  1  sole clock; all state changes on rising edge.
  - rst_n  input  1  synchronous active-low reset.
  - start  input  1  begin a scan; sampled only in IDLE.
  - target  input  1  output value being searched for; latched with start.
  - ready  input  1  consumer accepts vec when valid.
  - busy  output  1  high in any state other than IDLE.
  - valid  output  1  vec holds a matching input vector.
  - vec  output  5  matching vector, bit 4 = in[4].
  - done  output  1  one-cycle pulse at scan end.
  - match_cnt  output  6  number of matches accepted in the current or last scan.
- REQ-003 The design SHALL use one clock, and reset SHALL be synchronous and active-low.

Function
- REQ-004 The evaluated function SHALL be f(v) = (v[4] | v[3]) & v[2] & (~v[1] | v[0]).
- REQ-005 A scan SHALL enumerate idx from 0 to 31 ascending and present every idx where f(idx) == target. This inverts the function: given an output value, it yields every input that produces it.
- REQ-006 FSM states SHALL be IDLE, SCAN, HOLD and DONE.
- REQ-007 In IDLE, start=1 SHALL latch target, clear idx and match_cnt, and move to SCAN. In any other state, start SHALL be ignored.
- REQ-008 SCAN SHALL evaluate one idx per cycle:
  - On a match: register vec<=idx and valid<=1, then go to HOLD.
  - No match and idx<31: increment idx.
  - No match and idx==31: go to DONE.
- REQ-009 In HOLD, vec and valid SHALL stay stable while ready=0.
- REQ-010 In HOLD with ready=1:
  - clear valid and increment match_cnt;
  - if idx==31, go to DONE;
  - otherwise increment idx and go to SCAN.
- REQ-011 valid and done SHALL be registered outputs with no combinational path from ready.
- REQ-012 Latency: the first valid SHALL appear (idx+1) cycles after the start-sampling edge. For target=1 this is 13 cycles, with vec=12.
- REQ-013 DONE SHALL assert done for exactly one cycle, then return to IDLE. match_cnt SHALL hold its value until the next accepted start.
- REQ-014 Wrap: idx SHALL never wrap past 31 within a scan. idx 31 SHALL be evaluated exactly once.
- REQ-015 Full-scan totals SHALL be: target=1 gives 9 matches (12,13,15,20,21,23,28,29,31); target=0 gives 23.

Reset
- REQ-016 When rst_n=0 at a clock edge, the block SHALL enter IDLE from any state, including mid-scan or in HOLD.
- REQ-017 Reset values SHALL be: busy=0, valid=0, vec=0, done=0, match_cnt=0, idx=0, latched target=0.
- REQ-018 After reset, start SHALL be accepted on the first edge with rst_n=1.

Configuration
- REQ-019 Macro MINTERM_SCAN_COUNT_EN:
  - When defined, match_cnt SHALL be implemented as specified.
  - When undefined, match_cnt SHALL be tied to 0, no counter register SHALL exist, and all other behaviour SHALL be unchanged.

Structure
- REQ-020 Package minterm_scan_pkg SHALL hold the FSM state enum, VEC_W=5, LAST_IDX=31 and CNT_W=6.
- REQ-021 Sub-module func_eval SHALL be purely combinational: 5-bit input, 1-bit f output per REQ-004. It SHALL be instantiated once.

Verification
- REQ-022 Bench SHALL cover these scenarios:
  - Reset, then start with target=1 and ready=1 constantly: vec sequence 12,13,15,20,21,23,28,29,31; done one pulse; match_cnt=9.
  - Start with target=0 and ready=1: 23 vectors, first 0,1,2, last 30; match_cnt=23.
  - target=1 with ready held 0 for 5 cycles at first valid: vec stays 12, valid stays 1; vec 13 appears only after ready rises.
  - Start pulsed while busy: ignored; sequence and count unchanged.
  - rst_n=0 in HOLD at vec=20: next cycle all outputs 0 and busy=0; a new start rescans from idx 0.
  - Without MINTERM_SCAN_COUNT_EN: match_cnt=0 throughout, vec sequence identical to the first scenario.
